// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and request/ready instruction-fetch sequencer with stall and halt.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PC_Next,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        IMem_Ready,
    input  logic [15:0] IMem_Rdata,
    output logic [15:0] PC_Out,
    output logic [15:0] PC2_Out,
    output logic        IMem_Req,
    output logic [15:0] IMem_Addr,
    output logic [15:0] Inst_Out,
    output logic        Inst_Valid,
    output logic        Halted
);
    typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;
    state_t state, next_state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            PC_Out   <= RESET_PC;
            Inst_Out <= 16'h0000;
        end else begin
            state <= next_state;
            if (state == FETCH && IMem_Ready)
                Inst_Out <= IMem_Rdata;
            // instructions are halfword-aligned, so an odd target is forced even
            if (state == EXEC && !Halt && !Stall)
                PC_Out <= {PC_Next[15:1], 1'b0};
        end
    end
    always_comb begin
        next_state = state;
        next_state = state == BOOT  ? FETCH :
                     state == FETCH ? (IMem_Ready ? EXEC : FETCH) :
                     state == EXEC  ? (Halt ? HALT : Stall ? EXEC : FETCH) :
                                      HALT;
    end
    // Inst_Valid is exactly "in EXEC": set by the ready edge, cleared by the edge leaving EXEC
    assign Inst_Valid = state == EXEC;
    assign Halted     = state == HALT;
    assign IMem_Req   = state == FETCH;
    assign IMem_Addr  = PC_Out;
    assign PC2_Out    = PC_Out + 16'd2;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed test of boot, sequential flow, jumps, wait states, stall/halt and async reset.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] PC_Next = 16'h0000;
    logic        Stall = 1'b0;
    logic        Halt = 1'b0;
    logic        IMem_Ready = 1'b1;
    logic [15:0] IMem_Rdata = 16'h0000;
    logic [15:0] PC_Out, PC2_Out, IMem_Addr, Inst_Out;
    logic        IMem_Req, Inst_Valid, Halted;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_pc;

    pc_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .PC_Next(PC_Next), .Stall(Stall), .Halt(Halt),
        .IMem_Ready(IMem_Ready), .IMem_Rdata(IMem_Rdata), .PC_Out(PC_Out), .PC2_Out(PC2_Out),
        .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .Inst_Out(Inst_Out),
        .Inst_Valid(Inst_Valid), .Halted(Halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check("rst_pc", PC_Out, 16'h0000);
        check("rst_pc2", PC2_Out, 16'h0002);
        check("rst_req", {15'b0, IMem_Req}, 16'h0);
        check("rst_inst", Inst_Out, 16'h0000);
        check("rst_valid", {15'b0, Inst_Valid}, 16'h0);
        check("rst_halted", {15'b0, Halted}, 16'h0);
        tick();
        rst_n = 1'b1;
        #1 check("boot_req", {15'b0, IMem_Req}, 16'h0);
        tick();
        exp_pc = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            check("seq_fetch_req", {15'b0, IMem_Req}, 16'h1);
            check("seq_fetch_addr", IMem_Addr, exp_pc);
            check("seq_fetch_valid", {15'b0, Inst_Valid}, 16'h0);
            IMem_Rdata = 16'hA000 + 16'(i);
            IMem_Ready = 1'b1;
            tick();
            check("seq_exec_valid", {15'b0, Inst_Valid}, 16'h1);
            check("seq_exec_inst", Inst_Out, 16'hA000 + 16'(i));
            check("seq_exec_pc", PC_Out, exp_pc);
            check("seq_exec_req", {15'b0, IMem_Req}, 16'h0);
            PC_Next = exp_pc + 16'd2;
            tick();
            exp_pc = exp_pc + 16'd2;
        end
        check("seq_pc_end", PC_Out, 16'h0008);
        IMem_Rdata = 16'hB000;
        tick();
        PC_Next = 16'h1235;
        tick();
        check("jmp_odd_pc", PC_Out, 16'h1234);
        check("jmp_odd_pc2", PC2_Out, 16'h1236);
        IMem_Rdata = 16'hB001;
        tick();
        PC_Next = 16'hFFFF;
        tick();
        check("jmp_top_pc", PC_Out, 16'hFFFE);
        check("jmp_top_pc2", PC2_Out, 16'h0000);
        IMem_Ready = 1'b0;
        IMem_Rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {15'b0, IMem_Req}, 16'h1);
            check("wait_addr", IMem_Addr, 16'hFFFE);
            check("wait_valid", {15'b0, Inst_Valid}, 16'h0);
            check("wait_inst", Inst_Out, 16'hB001);
            tick();
        end
        check("wait_req4", {15'b0, IMem_Req}, 16'h1);
        check("wait_addr4", IMem_Addr, 16'hFFFE);
        IMem_Ready = 1'b1;
        IMem_Rdata = 16'hC000;
        tick();
        check("wait_done_valid", {15'b0, Inst_Valid}, 16'h1);
        check("wait_done_inst", Inst_Out, 16'hC000);
        Stall = 1'b1;
        PC_Next = 16'h4000;
        IMem_Rdata = 16'h5555;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_pc", PC_Out, 16'hFFFE);
            check("stall_inst", Inst_Out, 16'hC000);
            check("stall_valid", {15'b0, Inst_Valid}, 16'h1);
        end
        Halt = 1'b1;
        tick();
        check("halt_halted", {15'b0, Halted}, 16'h1);
        check("halt_req", {15'b0, IMem_Req}, 16'h0);
        check("halt_valid", {15'b0, Inst_Valid}, 16'h0);
        check("halt_pc", PC_Out, 16'hFFFE);
        Halt = 1'b0;
        Stall = 1'b0;
        tick();
        tick();
        check("halt_stay", {15'b0, Halted}, 16'h1);
        check("halt_stay_pc", PC_Out, 16'hFFFE);
        check("halt_stay_req", {15'b0, IMem_Req}, 16'h0);
        rst_n = 1'b0;
        #1;
        check("rst2_pc", PC_Out, 16'h0000);
        check("rst2_halted", {15'b0, Halted}, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        IMem_Rdata = 16'hD000;
        tick();
        PC_Next = 16'h0002;
        tick();
        IMem_Ready = 1'b0;
        tick();
        check("mid_req", {15'b0, IMem_Req}, 16'h1);
        check("mid_addr", IMem_Addr, 16'h0002);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_pc", PC_Out, 16'h0000);
        check("mid_rst_req", {15'b0, IMem_Req}, 16'h0);
        check("mid_rst_inst", Inst_Out, 16'h0000);
        check("mid_rst_valid", {15'b0, Inst_Valid}, 16'h0);
        rst_n = 1'b1;
        #0.5;
        check("mid_boot_req", {15'b0, IMem_Req}, 16'h0);
        IMem_Ready = 1'b1;
        IMem_Rdata = 16'hE000;
        tick();
        check("restart_req", {15'b0, IMem_Req}, 16'h1);
        check("restart_addr", IMem_Addr, 16'h0000);
        tick();
        check("restart_inst", Inst_Out, 16'hE000);
        check("restart_valid", {15'b0, Inst_Valid}, 16'h1);
        check("restart_pc", PC_Out, 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
